// File: rtl/probe_message_decoder.sv
// probe_message_decoder
//
// Reassembles the LSB-first probe trace byte stream into messages of 2, 3, 6
// or 7 bytes and presents each decoded message as one event on a valid/ready
// port, together with a running 32-bit absolute timestamp.
//
// Message layout, in stream order:
//   bytes 0-1 : header    [15:2] cycle_delay, [1] a_en, [0] b_en
//   bytes 2-5 : checkpoint A (only when a_en) [31:26] id, [25:23] channel,
//               [22:1] addr, [0] wen
//   last byte : checkpoint B (only when b_en) [7:6] must be 0, [5:0] id
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   byte_in, byte_valid_in    incoming stream byte and its valid
//   byte_ready_out            high in every collect state, low while an event
//                             waits in OUT
//   evt_valid_out             event held on the evt_* outputs
//   evt_ready_in              consumer accepts the event
//   evt_timestamp_out         timestamp including this message's delay
//   evt_delay_out             header cycle_delay
//   evt_a_*_out, evt_b_*_out  checkpoint fields, zero when absent
//   err_out                   one-cycle pulse on OUT entry for a malformed
//                             message (delay of zero or B byte [7:6] != 0)
//
// Handshakes: a byte moves on a cycle with byte_valid_in && byte_ready_out;
// an event moves on a cycle with evt_valid_out && evt_ready_in. Fields stay
// constant while evt_valid_out is high and the event has not been taken.
//
// Build option PROBE_DECODE_HEARTBEAT_EN: when defined, heartbeat messages
// (a_en = b_en = 0) are emitted as events; when undefined they only advance
// the timestamp and the decoder goes straight back to HDR0.

module probe_message_decoder (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic        byte_ready_out,
    output logic        evt_valid_out,
    input  logic        evt_ready_in,
    output logic [31:0] evt_timestamp_out,
    output logic [13:0] evt_delay_out,
    output logic        evt_a_en_out,
    output logic [5:0]  evt_a_id_out,
    output logic [2:0]  evt_a_channel_out,
    output logic [21:0] evt_a_addr_out,
    output logic        evt_a_wen_out,
    output logic        evt_b_en_out,
    output logic [5:0]  evt_b_id_out,
    output logic        err_out
);

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_A    = 3'd2,
        S_B    = 3'd3,
        S_OUT  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] hdr_q, hdr_d;
    logic [31:0] a_q, a_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] ts_q, ts_d;

    logic [13:0] delay_q, delay_d;
    logic        a_en_q, a_en_d;
    logic [5:0]  a_id_q, a_id_d;
    logic [2:0]  a_ch_q, a_ch_d;
    logic [21:0] a_addr_q, a_addr_d;
    logic        a_wen_q, a_wen_d;
    logic        b_en_q, b_en_d;
    logic [5:0]  b_id_q, b_id_d;
    logic        err_q, err_d;

    // Header and checkpoint A as seen on the cycle that completes them: the
    // byte arriving now is merged with the bytes already stored.
    logic [15:0] msg_hdr;
    logic [31:0] msg_a;
    logic        finish;  // final byte of a message accepted this cycle
    logic        emit;    // that message produces an event

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        a_d      = a_q;
        idx_d    = idx_q;
        ts_d     = ts_q;
        delay_d  = delay_q;
        a_en_d   = a_en_q;
        a_id_d   = a_id_q;
        a_ch_d   = a_ch_q;
        a_addr_d = a_addr_q;
        a_wen_d  = a_wen_q;
        b_en_d   = b_en_q;
        b_id_d   = b_id_q;
        err_d    = 1'b0;
        finish   = 1'b0;
        emit     = 1'b0;

        msg_hdr = (state_q == S_HDR1) ? {byte_in, hdr_q[7:0]} : hdr_q;
        msg_a   = (state_q == S_A) ? {byte_in, a_q[23:0]} : a_q;

        case (state_q)
            S_HDR0: begin
                if (byte_valid_in) begin
                    hdr_d[7:0] = byte_in;
                    state_d    = S_HDR1;
                end
            end
            S_HDR1: begin
                if (byte_valid_in) begin
                    hdr_d[15:8] = byte_in;
                    if (msg_hdr[1]) begin
                        idx_d   = 2'd0;
                        state_d = S_A;
                    end else if (msg_hdr[0]) begin
                        state_d = S_B;
                    end else begin
                        finish = 1'b1;
`ifdef PROBE_DECODE_HEARTBEAT_EN
                        emit    = 1'b1;
                        state_d = S_OUT;
`else
                        state_d = S_HDR0;
`endif
                    end
                end
            end
            S_A: begin
                if (byte_valid_in) begin
                    a_d[{idx_q, 3'b000} +: 8] = byte_in;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (hdr_q[0]) begin
                            state_d = S_B;
                        end else begin
                            finish  = 1'b1;
                            emit    = 1'b1;
                            state_d = S_OUT;
                        end
                    end
                end
            end
            S_B: begin
                if (byte_valid_in) begin
                    finish  = 1'b1;
                    emit    = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (evt_ready_in) begin
                    state_d = S_HDR0;
                end
            end
            default: begin
                state_d = S_HDR0;
            end
        endcase

        if (finish) begin
            ts_d = ts_q + {18'd0, msg_hdr[15:2]};
        end

        if (emit) begin
            delay_d  = msg_hdr[15:2];
            a_en_d   = msg_hdr[1];
            a_id_d   = msg_hdr[1] ? msg_a[31:26] : 6'd0;
            a_ch_d   = msg_hdr[1] ? msg_a[25:23] : 3'd0;
            a_addr_d = msg_hdr[1] ? msg_a[22:1] : 22'd0;
            a_wen_d  = msg_hdr[1] & msg_a[0];
            b_en_d   = msg_hdr[0];
            // With b_en set the emitting byte is always the B byte.
            b_id_d   = msg_hdr[0] ? byte_in[5:0] : 6'd0;
            err_d    = (msg_hdr[15:2] == 14'd0) ||
                       (msg_hdr[0] && (byte_in[7:6] != 2'b00));
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_HDR0;
            hdr_q    <= 16'd0;
            a_q      <= 32'd0;
            idx_q    <= 2'd0;
            ts_q     <= 32'd0;
            delay_q  <= 14'd0;
            a_en_q   <= 1'b0;
            a_id_q   <= 6'd0;
            a_ch_q   <= 3'd0;
            a_addr_q <= 22'd0;
            a_wen_q  <= 1'b0;
            b_en_q   <= 1'b0;
            b_id_q   <= 6'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            a_q      <= a_d;
            idx_q    <= idx_d;
            ts_q     <= ts_d;
            delay_q  <= delay_d;
            a_en_q   <= a_en_d;
            a_id_q   <= a_id_d;
            a_ch_q   <= a_ch_d;
            a_addr_q <= a_addr_d;
            a_wen_q  <= a_wen_d;
            b_en_q   <= b_en_d;
            b_id_q   <= b_id_d;
            err_q    <= err_d;
        end
    end

    assign byte_ready_out    = (state_q != S_OUT);
    assign evt_valid_out     = (state_q == S_OUT);
    // ts_q only moves on a final byte, which cannot happen while in OUT, so
    // it doubles as the registered event timestamp.
    assign evt_timestamp_out = ts_q;
    assign evt_delay_out     = delay_q;
    assign evt_a_en_out      = a_en_q;
    assign evt_a_id_out      = a_id_q;
    assign evt_a_channel_out = a_ch_q;
    assign evt_a_addr_out    = a_addr_q;
    assign evt_a_wen_out     = a_wen_q;
    assign evt_b_en_out      = b_en_q;
    assign evt_b_id_out      = b_id_q;
    assign err_out           = err_q;

endmodule

// File: tb/tb_probe_message_decoder.sv
// Testbench for probe_message_decoder: table-driven known messages, directed
// multi-cycle corner cases (consumer back-pressure, timestamp wrap, reset
// mid-message and in OUT) and randomized messages checked against a
// field-level reference model through an expected-event queue.

module tb_probe_message_decoder;

`ifdef PROBE_DECODE_HEARTBEAT_EN
    localparam bit HB_EN = 1'b1;
`else
    localparam bit HB_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid_in = 1'b0;
    logic        byte_ready_out;
    logic        evt_valid_out;
    logic        evt_ready_in = 1'b1;
    logic [31:0] evt_timestamp_out;
    logic [13:0] evt_delay_out;
    logic        evt_a_en_out;
    logic [5:0]  evt_a_id_out;
    logic [2:0]  evt_a_channel_out;
    logic [21:0] evt_a_addr_out;
    logic        evt_a_wen_out;
    logic        evt_b_en_out;
    logic [5:0]  evt_b_id_out;
    logic        err_out;

    probe_message_decoder dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .byte_in           (byte_in),
        .byte_valid_in     (byte_valid_in),
        .byte_ready_out    (byte_ready_out),
        .evt_valid_out     (evt_valid_out),
        .evt_ready_in      (evt_ready_in),
        .evt_timestamp_out (evt_timestamp_out),
        .evt_delay_out     (evt_delay_out),
        .evt_a_en_out      (evt_a_en_out),
        .evt_a_id_out      (evt_a_id_out),
        .evt_a_channel_out (evt_a_channel_out),
        .evt_a_addr_out    (evt_a_addr_out),
        .evt_a_wen_out     (evt_a_wen_out),
        .evt_b_en_out      (evt_b_en_out),
        .evt_b_id_out      (evt_b_id_out),
        .err_out           (err_out)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0] ts;
        logic [13:0] delay;
        logic        a_en;
        logic [5:0]  a_id;
        logic [2:0]  ch;
        logic [21:0] addr;
        logic        wen;
        logic        b_en;
        logic [5:0]  b_id;
        logic        err;
    } evt_t;

    typedef struct {
        bit          rst;
        int          len;
        logic [55:0] bytes;
        bit          hb;
        evt_t        exp;
    } vec_t;

    evt_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    int          rdy_mode = 0;   // 0 always ready, 1 random, 2 held low
    bit          stall_en = 1'b0;
    logic [31:0] ts_model = 32'd0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: event contents straight from the message fields.
    function automatic evt_t model_evt(input logic [31:0] ts, input logic [13:0] d,
                                       input bit a_en, input logic [31:0] aw,
                                       input bit b_en, input logic [7:0] bb);
        evt_t e;
        e = '0;
        e.ts    = ts;
        e.delay = d;
        e.a_en  = a_en;
        if (a_en) begin
            e.a_id = aw[31:26];
            e.ch   = aw[25:23];
            e.addr = aw[22:1];
            e.wen  = aw[0];
        end
        e.b_en = b_en;
        if (b_en) e.b_id = bb[5:0];
        e.err = (d == 14'd0) || (b_en && (bb[7:6] != 2'b00));
        return e;
    endfunction

    function automatic evt_t mk_evt(input logic [31:0] ts, input logic [13:0] d,
                                    input bit a_en, input logic [5:0] a_id,
                                    input logic [2:0] ch, input logic [21:0] addr,
                                    input bit wen, input bit b_en,
                                    input logic [5:0] b_id, input bit err);
        evt_t e;
        e.ts = ts; e.delay = d; e.a_en = a_en; e.a_id = a_id; e.ch = ch;
        e.addr = addr; e.wen = wen; e.b_en = b_en; e.b_id = b_id; e.err = err;
        return e;
    endfunction

    function automatic vec_t mk_vec(input bit rst, input int len, input logic [55:0] bytes,
                                    input bit hb, input evt_t exp);
        vec_t v;
        v.rst = rst; v.len = len; v.bytes = bytes; v.hb = hb; v.exp = exp;
        return v;
    endfunction

    // ---------------- consumer ready driver ----------------
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            case (rdy_mode)
                0:       evt_ready_in = 1'b1;
                1:       evt_ready_in = ($urandom_range(0, 3) != 0);
                default: evt_ready_in = 1'b0;
            endcase
        end
    end

    // ---------------- event monitor ----------------
    bit   prev_valid = 1'b0;
    evt_t mon_e;
    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                prev_valid = 1'b0;
            end else if (evt_valid_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual ts=%0d delay=%0d required no event at %0t",
                             evt_timestamp_out, evt_delay_out, $time);
                end else begin
                    mon_e = exp_q[0];
                    check("evt_ts", 128'(evt_timestamp_out), 128'(mon_e.ts));
                    check("evt_fields",
                          128'({evt_delay_out, evt_a_en_out, evt_a_id_out, evt_a_channel_out,
                                evt_a_addr_out, evt_a_wen_out, evt_b_en_out, evt_b_id_out}),
                          128'({mon_e.delay, mon_e.a_en, mon_e.a_id, mon_e.ch,
                                mon_e.addr, mon_e.wen, mon_e.b_en, mon_e.b_id}));
                    if (!prev_valid) check("evt_err", 128'(err_out), 128'(mon_e.err));
                    else             check("err_hold", 128'(err_out), 128'(0));
                    if (evt_ready_in) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
                prev_valid = !evt_ready_in;
            end else begin
                check("err_idle", 128'(err_out), 128'(0));
                prev_valid = 1'b0;
            end
        end
    end

    // ---------------- driver tasks (entered at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b);
        int cnt;
        if (stall_en) begin
            byte_valid_in = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
        end
        byte_in       = b;
        byte_valid_in = 1'b1;
        cnt = 0;
        while (!byte_ready_out && cnt < 1000) begin
            @(negedge clk_in);
            cnt++;
        end
        if (cnt >= 1000) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout actual=not accepted required=accepted byte %0h", b);
            byte_valid_in = 1'b0;
            return;
        end
        @(negedge clk_in);
        byte_valid_in = 1'b0;
    endtask

    task automatic send_msg(input logic [13:0] d, input bit a_en, input logic [31:0] aw,
                            input bit b_en, input logic [7:0] bb);
        logic [15:0] hdr;
        bit          want;
        hdr      = {d, a_en, b_en};
        ts_model = ts_model + 32'(d);
        want     = a_en || b_en || HB_EN;
        if (want) exp_q.push_back(model_evt(ts_model, d, a_en, aw, b_en, bb));
        send_byte(hdr[7:0]);
        send_byte(hdr[15:8]);
        if (a_en) for (int i = 0; i < 4; i++) send_byte(aw[i*8 +: 8]);
        if (b_en) send_byte(bb);
        check("evt_latency", 128'(evt_valid_out), 128'(want));
    endtask

    task automatic do_reset();
        rst_in        = 1'b1;
        byte_valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        exp_q.delete();
        ts_model = 32'd0;
        check("rst_ready", 128'(byte_ready_out), 128'(1));
        check("rst_valid", 128'(evt_valid_out), 128'(0));
        check("rst_err", 128'(err_out), 128'(0));
        check("rst_ts", 128'(evt_timestamp_out), 128'(0));
        check("rst_fields",
              128'({evt_delay_out, evt_a_en_out, evt_a_id_out, evt_a_channel_out,
                    evt_a_addr_out, evt_a_wen_out, evt_b_en_out, evt_b_id_out}),
              128'(0));
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 2000) begin
            @(negedge clk_in);
            cnt++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
    endtask

    // ---------------- main sequence ----------------
    localparam int NV = 8;
    vec_t        tv[NV];
    bit          want;
    int          hs_before;
    int          kind;
    logic [13:0] rd;
    logic [31:0] raw;
    logic [7:0]  rb;

    initial begin
        tv[0] = mk_vec(1, 3, 56'h2A0015, 0,
                       mk_evt(32'd5, 14'd5, 0, 6'd0, 3'd0, 22'd0, 0, 1, 6'd42, 0));
        tv[1] = mk_vec(0, 6, 56'h0D02468B0006, 0,
                       mk_evt(32'd6, 14'd1, 1, 6'd3, 3'd2, 22'h012345, 1, 0, 6'd0, 0));
        tv[2] = mk_vec(1, 2, 56'hFFFC, 1,
                       mk_evt(32'd16383, 14'd16383, 0, 6'd0, 3'd0, 22'd0, 0, 0, 6'd0, 0));
        tv[3] = mk_vec(0, 3, 56'h2A0015, 0,
                       mk_evt(32'd16388, 14'd5, 0, 6'd0, 3'd0, 22'd0, 0, 1, 6'd42, 0));
        tv[4] = mk_vec(0, 3, 56'hEA0015, 0,
                       mk_evt(32'd16393, 14'd5, 0, 6'd0, 3'd0, 22'd0, 0, 1, 6'd42, 1));
        tv[5] = mk_vec(0, 2, 56'h0000, 1,
                       mk_evt(32'd16393, 14'd0, 0, 6'd0, 3'd0, 22'd0, 0, 0, 6'd0, 1));
        tv[6] = mk_vec(0, 7, 56'h110D02468B0007, 0,
                       mk_evt(32'd16394, 14'd1, 1, 6'd3, 3'd2, 22'h012345, 1, 1, 6'd17, 0));
        tv[7] = mk_vec(0, 6, 56'hFC0000000006, 0,
                       mk_evt(32'd16395, 14'd1, 1, 6'd63, 3'd0, 22'd0, 0, 0, 6'd0, 0));

        @(negedge clk_in);

        // Known messages from the table.
        for (int i = 0; i < NV; i++) begin
            if (tv[i].rst) do_reset();
            want = !tv[i].hb || HB_EN;
            if (want) exp_q.push_back(tv[i].exp);
            ts_model = tv[i].exp.ts;
            for (int k = 0; k < tv[i].len; k++) send_byte(tv[i].bytes[k*8 +: 8]);
            check("tv_latency", 128'(evt_valid_out), 128'(want));
        end
        drain();

        // Consumer holds ready low for 10 cycles on a 7-byte message while the
        // next message's first byte is already offered.
        rdy_mode = 2;
        send_msg(14'd1, 1, 32'h0D02468B, 1, 8'h11);
        ts_model = ts_model + 32'd5;
        exp_q.push_back(model_evt(ts_model, 14'd5, 0, 32'd0, 1, 8'h2A));
        hs_before     = hs_cnt;
        byte_in       = 8'h15;
        byte_valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            check("stall_ready", 128'(byte_ready_out), 128'(0));
            check("stall_valid", 128'(evt_valid_out), 128'(1));
        end
        rdy_mode = 0;
        send_byte(8'h15);
        check("accept_after_hs", 128'(hs_cnt - hs_before), 128'(1));
        send_byte(8'h00);
        send_byte(8'h2A);
        drain();

        // Randomized messages with input stalls and random consumer ready.
        do_reset();
        rdy_mode = 1;
        stall_en = 1'b1;
        repeat (150) begin
            kind = $urandom_range(0, 3);
            rd   = ($urandom_range(0, 9) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
            raw  = $urandom;
            rb   = ($urandom_range(0, 5) == 0) ? 8'($urandom) : {2'b00, 6'($urandom)};
            send_msg(rd, kind[1], raw, kind[0], rb);
        end
        drain();
        stall_en = 1'b0;
        rdy_mode = 0;

        // Timestamp wrap from a preloaded value.
        do_reset();
        force dut.ts_q = 32'hFFFF_FFF0;
        @(negedge clk_in);
        release dut.ts_q;
        @(negedge clk_in);
        ts_model = 32'hFFFF_FFF0;
        send_msg(14'd16383, 0, 32'd0, 1, 8'h05);
        send_msg(14'd16383, 0, 32'd0, 1, 8'h06);
        drain();

        // Reset after 3 bytes of a 6-byte message.
        send_byte(8'h06);
        send_byte(8'h00);
        send_byte(8'h8B);
        do_reset();
        repeat (3) @(negedge clk_in);
        check("partial_no_evt", 128'(evt_valid_out), 128'(0));
        send_msg(14'd5, 0, 32'd0, 1, 8'h2A);
        drain();

        // Reset while an event waits in OUT drops it.
        rdy_mode = 2;
        send_msg(14'd3, 0, 32'd0, 1, 8'h01);
        do_reset();
        rdy_mode = 0;
        repeat (3) @(negedge clk_in);
        check("out_rst_no_evt", 128'(evt_valid_out), 128'(0));
        send_msg(14'd7, 1, 32'hA5A5_5A5B, 0, 8'h00);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/probe_message_decoder.md
# probe_message_decoder

Host-side decoder for the probe trace byte stream: it accepts bytes LSB-first as produced by the probe message encoder and reassembles the variable-length messages (2, 3, 6 or 7 bytes). Each message is decoded into header, checkpoint A and checkpoint B fields, and a running 32-bit absolute timestamp is accumulated from the per-message cycle delays. The block sits behind the byte receiver, for example a UART RX or loopback FIFO, and feeds trace consumers such as a display, a checker or a memory logger through a valid/ready event port.

## Interface
- No parameters. Field widths are fixed by the message format.
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-high
- byte_in  input  8  incoming stream byte
- byte_valid_in  input  1  byte_in valid
- byte_ready_out  output  1  decoder can accept a byte this cycle
- evt_valid_out  output  1  decoded event held on evt_* outputs
- evt_ready_in  input  1  consumer accepts the event
- evt_timestamp_out  output  32  accumulated cycle count including this message's delay
- evt_delay_out  output  14  header cycle_delay
- evt_a_en_out  output  1  checkpoint A present
- evt_a_id_out  output  6  checkpoint A id
- evt_a_channel_out  output  3  checkpoint A channel
- evt_a_addr_out  output  22  checkpoint A address field (memory address bits [24:3])
- evt_a_wen_out  output  1  checkpoint A write enable
- evt_b_en_out  output  1  checkpoint B present
- evt_b_id_out  output  6  checkpoint B id
- err_out  output  1  one-cycle pulse on a malformed message

## Operation
- Byte transfer occurs when byte_valid_in && byte_ready_out.
- Header layout (16 bits): bits [15:2] cycle_delay, bit [1] a_en, bit [0] b_en. Bytes 0 and 1 carry the header, LSB first.
- Checkpoint A (32 bits): [31:26] id, [25:23] channel, [22:1] addr, [0] wen. When a_en=1, bytes 2–5 carry it, LSB first.
- Checkpoint B byte: [7:6] must be 0, [5:0] id. It is the last byte whenever b_en=1.
- FSM states:
  - HDR0: capture the low header byte, go to HDR1.
  - HDR1: capture the high header byte. Next state is A if a_en, else B if b_en, else OUT.
  - A: capture 4 bytes using a 2-bit index, then go to B if b_en, else OUT.
  - B: capture 1 byte, go to OUT.
  - OUT: evt_valid_out=1. When evt_ready_in=1, go to HDR0.
- byte_ready_out=1 in HDR0, HDR1, A and B; 0 in OUT.
- On acceptance of the final byte of a message:
  - the timestamp register is updated to timestamp + cycle_delay, modulo 2^32 (wraps silently);
  - the event fields are registered.
- Event fields are stable while evt_valid_out=1 and evt_ready_in=0.
- err_out pulses on the OUT entry cycle if cycle_delay==0 or B byte [7:6]!=0. The event is still emitted with the fields as received. There is no resynchronisation.
- Fields of absent checkpoints output 0.

## Timing
- Reset values:
  - state HDR0, timestamp 0;
  - evt_valid_out 0, err_out 0, all evt_* fields 0;
  - byte_ready_out 1 from the first cycle after reset.
- Latency: evt_valid_out rises the cycle after the final byte is accepted.
- Minimum cost per message is N+1 cycles, where N is the message length, because OUT lasts at least 1 cycle.
- Input stall cycles (byte_valid_in=0) are legal in any collect state and hold the state.
- Reset mid-message discards the partial message and clears the timestamp. Reset while in OUT drops the pending event.

## Configuration
- PROBE_DECODE_HEARTBEAT_EN
  - Defined: messages with a_en=b_en=0 (heartbeats) go through OUT and are emitted as events.
  - Undefined: heartbeats update the timestamp, then return directly from HDR1 to HDR0 with no event and no err_out check. Only the delay==0 check is skipped.

## Test plan
- Bytes 15 00 2A -> event: delay 5, b_en 1, b_id 42, a_en 0, timestamp 5.
- Bytes 06 00 8B 46 02 0D -> event: delay 1, a_id 3, channel 2, addr 0x12345, wen 1, b_en 0, timestamp advances by 1.
- Heartbeat bytes FC FF followed by 15 00 2A:
  - with macro: two events, timestamps 16383 and 16388;
  - without macro: one event, timestamp 16388.
- 7-byte message with evt_ready_in held 0 for 10 cycles:
  - byte_ready_out stays 0 and evt_* fields stay stable;
  - the next message's bytes are accepted only after the handshake.
- Bytes 15 00 EA -> event with b_id 42 plus an err_out pulse. Bytes 00 00 -> err_out (macro defined).
- Timestamp preloaded near wrap with messages of delay 16383 -> value wraps to delay minus remainder. Reset asserted after 3 bytes of a 6-byte message -> no event, and the next clean message decodes with timestamp equal to its delay.
